up_down_counter_param: RTL
==========================

Name: up_down_counter_param

Overview:
- Parametrised successor to the 4-bit up/down counter.
- Configurable width and modulo limit.
- Adds count enable, synchronous clear, parallel load and wrap-or-saturate mode.
- Adds a terminal-count flag and a registered carry/borrow event pulse.
- Used as a general event/position counter in datapath and timer logic.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- MAX_VAL, 2**WIDTH-1, highest count value; count range is 0..MAX_VAL; must be <= 2**WIDTH-1.
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  count enable.
- dir  in  1  direction: 1 = up, 0 = down.
- clear  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  registered count.
- tc  out  1  terminal count, combinational.
- carry  out  1  registered one-cycle boundary event pulse.

Behaviour:
- Reset (reset_n=0, asynchronous): q=0, carry=0 immediately. Held while reset_n=0.
- Release is synchronous to clk: the first update happens on the first rising edge with reset_n=1.
- Per-edge priority: clear > load > en. clear and load act regardless of en.
- clear: q<=0, carry<=0.
- load:
  - q<=load_val when load_val<=MAX_VAL, else q<=MAX_VAL (clamped).
  - carry<=0.
- en=1, dir=1, q<MAX_VAL: q<=q+1, carry<=0.
- en=1, dir=1, q==MAX_VAL:
  - SATURATE=0: q<=0, carry<=1.
  - SATURATE=1: q holds MAX_VAL, carry<=1 (overflow attempt flagged).
- en=1, dir=0, q>0: q<=q-1, carry<=0.
- en=1, dir=0, q==0:
  - SATURATE=0: q<=MAX_VAL, carry<=1.
  - SATURATE=1: q holds 0, carry<=1.
- en=0 with no clear/load: q holds, carry<=0.
- carry lasts exactly one cycle per boundary event. Continuous counting in SATURATE=1 at a limit keeps carry high every cycle.
- tc = en & ((dir & q==MAX_VAL) | (~dir & q==0)). Combinational; predicts carry on the next edge unless clear/load intervenes.
- dir may change on any cycle. A direction change takes effect on the same edge, with no extra latency or glitch state.
- Arithmetic:
  - No intermediate value may exceed WIDTH bits.
  - Modulo-MAX_VAL wrap is explicit, never reliant on natural 2**WIDTH overflow, unless MAX_VAL == 2**WIDTH-1.
- Reset asserted mid-count aborts immediately. Pending load/clear has no effect.

Optional Feature:
- Macro: UDCNT_MATCH_EN.
- When defined, adds:
  - Input match_val [WIDTH].
  - Output match [1], registered, reset 0.
- On any edge where q is written (clear, load or count), match <= (new q == match_val). On edges where q holds, match <= 0. Result: a one-cycle pulse on each arrival at match_val.
- In SATURATE=1 hold-at-limit cycles, q is not written, so match=0.
- When not defined: no match_val or match port and no compare logic. Behaviour is otherwise identical.

Test Plan:
1. Reset and basic count:
   - Setup: WIDTH=4, MAX_VAL=15, SATURATE=0; reset_n low 15 ns, then en=1, dir=1.
   - Required: q=0 during reset; q=1..10 on the following 10 edges; dir=0 then counts back 9..0.
2. Modulo wrap:
   - Setup: WIDTH=4, MAX_VAL=9; count up from 8.
   - Required: q 8->9->0; tc=1 while q=9; carry=1 for exactly the cycle after q=0 is reached.
   - Down from 0: q->9, carry pulse.
3. Saturate:
   - Setup: SATURATE=1, MAX_VAL=15; q=15, en=1, dir=1 for 3 edges.
   - Required: q stays 15, carry=1 on all 3 cycles.
   - At q=0 with dir=0: q stays 0, carry=1.
4. Priority and clamp:
   - Setup: clear=1, load=1, load_val=5 on the same edge.
   - Required: q=0.
   - Then load=1, load_val=12 with MAX_VAL=9: q=9, carry=0.
   - en=0 for 4 edges: q holds.
5. Async reset mid-count:
   - Setup: while counting at q=6, pulse reset_n low between edges.
   - Required: q=0 and carry=0 without waiting for a clk edge; counting resumes from 0 after release.
6. UDCNT_MATCH_EN:
   - Setup: match_val=3; count up from 0.
   - Required: match high only in the cycle q first equals 3.
   - Load 3 gives another pulse; holding at 3 with en=0 gives match=0.

Source files
------------

// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter: modulo or saturating limit, sync clear/load, tc flag, carry pulse.
// Optional feature macro UDCNT_MATCH_EN adds match_val input and a registered match pulse output.
module up_down_counter_param #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             dir,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UDCNT_MATCH_EN
    input  logic [WIDTH-1:0] match_val,
    output logic             match,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             carry
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Loads above the modulo limit are pinned to the limit.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    // Value taken when counting past the top: wrap to 0 or hold at MAX_VAL.
    function automatic logic [WIDTH-1:0] past_top();
        return SATURATE ? MAX_VAL : ZERO;
    endfunction

    // Value taken when counting below 0: wrap to MAX_VAL or hold at 0.
    function automatic logic [WIDTH-1:0] past_bottom();
        return SATURATE ? ZERO : MAX_VAL;
    endfunction

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             at_top, at_bot;

    assign at_top = (cnt_q == MAX_VAL);
    assign at_bot = (cnt_q == ZERO);

    always_comb begin
        cnt_d   = cnt_q;
        carry_d = 1'b0;
        if (clear) begin
            cnt_d = ZERO;
        end else if (load) begin
            cnt_d = clamp_load(load_val);
        end else if (en) begin
            if (dir) begin
                if (at_top) begin
                    cnt_d   = past_top();
                    carry_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                if (at_bot) begin
                    cnt_d   = past_bottom();
                    carry_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= ZERO;
            carry_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    assign q     = cnt_q;
    assign carry = carry_q;
    assign tc    = en & ((dir & at_top) | (~dir & at_bot));

`ifdef UDCNT_MATCH_EN
    // A saturating hold at a limit does not count as writing q, so it never matches.
    logic sat_hold, written, match_q;

    assign sat_hold = SATURATE & ~clear & ~load & en & ((dir & at_top) | (~dir & at_bot));
    assign written  = clear | load | (en & ~sat_hold);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_q <= 1'b0;
        end else begin
            match_q <= written & (cnt_d == match_val);
        end
    end

    assign match = match_q;
`endif

endmodule
